// File: rtl/mul_nibble_seq_pkg.sv
// Shared definitions for the nibble-serial multiplier: nibble width, state
// encoding and the partial-product shift amount.
package mul_nibble_seq_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN
    } state_t;

    // Bit position at which the (i, j) nibble partial product lands.
    function automatic int unsigned shift_amt(input int unsigned i, input int unsigned j);
        return int'(NIBBLE_W) * (i + j);
    endfunction

endpackage

// File: rtl/mul_nibble_seq_imul.sv
// 4x4 -> 8 unsigned combinational multiplier (IMUL), shared by every step
// of the sequential multiplier.
module mul_nibble_seq_imul (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    assign p = 8'(a) * 8'(b);

endmodule

// File: rtl/mul_nibble_seq.sv
// Nibble-serial unsigned multiplier: one 4x4 partial product per cycle,
// shifted and accumulated into a 2*OPERAND_WIDTH result.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for iStart; oResult holds the last product
// S_RUN  | one nibble-pair step per edge, i inner loop, j outer loop
module mul_nibble_seq
    import mul_nibble_seq_pkg::*;
#(
    parameter int OPERAND_WIDTH = 8
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       iStart,
    input  logic [OPERAND_WIDTH-1:0]   iA,
    input  logic [OPERAND_WIDTH-1:0]   iB,
    output logic                       oBusy,
    output logic                       oDone,
    output logic [2*OPERAND_WIDTH-1:0] oResult
);

    localparam int NIB = OPERAND_WIDTH / NIBBLE_W;
    localparam int PW  = 2 * OPERAND_WIDTH;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NIB - 1);

    if ((OPERAND_WIDTH < NIBBLE_W) || ((OPERAND_WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
        $error("mul_nibble_seq: OPERAND_WIDTH must be a positive multiple of 4");
    end

    state_t                     state;
    state_t                     state_nx;
    logic [CW-1:0]              i_cnt;
    logic [CW-1:0]              j_cnt;
    logic [OPERAND_WIDTH-1:0]   a_lat;
    logic [OPERAND_WIDTH-1:0]   b_lat;
    logic [PW-1:0]              acc;
    logic [3:0]                 a_nib;
    logic [3:0]                 b_nib;
    logic [7:0]                 pp;
    logic [PW-1:0]              pp_sh;
    logic                       last_step;

    assign a_nib     = a_lat[{i_cnt, 2'b00} +: NIBBLE_W];
    assign b_nib     = b_lat[{j_cnt, 2'b00} +: NIBBLE_W];
    assign pp_sh     = PW'(pp) << shift_amt(32'(i_cnt), 32'(j_cnt));
    assign last_step = (i_cnt == LAST_IDX) && (j_cnt == LAST_IDX);
    assign oBusy     = (state == S_RUN);

    mul_nibble_seq_imul u_imul (
        .a (a_nib),
        .b (b_nib),
        .p (pp)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (iStart)    state_nx = S_RUN;
            S_RUN:   if (last_step) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            i_cnt   <= '0;
            j_cnt   <= '0;
            a_lat   <= '0;
            b_lat   <= '0;
            acc     <= '0;
            oResult <= '0;
            oDone   <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (iStart) begin
                        a_lat <= iA;
                        b_lat <= iB;
                        acc   <= '0;
                        i_cnt <= '0;
                        j_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (last_step) begin
                        oResult <= acc + pp_sh;
                        oDone   <= 1'b1;
                        i_cnt   <= '0;
                        j_cnt   <= '0;
                    end else begin
                        acc <= acc + pp_sh;
                        if (i_cnt == LAST_IDX) begin
                            i_cnt <= '0;
                            j_cnt <= j_cnt + 1'b1;
                        end else begin
                            i_cnt <= i_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_nibble_seq.sv
// Self-checking bench for mul_nibble_seq at operand widths 4, 8 and 16,
// compared against plain arithmetic products and step-count latency.
module tb_mul_nibble_seq;

    logic        Clock;
    logic        Reset;
    logic        s4, s8, s16;
    logic [3:0]  a4, b4;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        busy4, busy8, busy16;
    logic        d4, d8, d16;
    logic [7:0]  r4;
    logic [15:0] r8;
    logic [31:0] r16;

    int ntests = 0;
    int nfail  = 0;
    int dones4 = 0, dones8 = 0, dones16 = 0;
    int exp4   = 0, exp8   = 0, exp16   = 0;

    mul_nibble_seq #(.OPERAND_WIDTH(4)) dut4 (
        .Clock(Clock), .Reset(Reset), .iStart(s4), .iA(a4), .iB(b4),
        .oBusy(busy4), .oDone(d4), .oResult(r4)
    );
    mul_nibble_seq #(.OPERAND_WIDTH(8)) dut8 (
        .Clock(Clock), .Reset(Reset), .iStart(s8), .iA(a8), .iB(b8),
        .oBusy(busy8), .oDone(d8), .oResult(r8)
    );
    mul_nibble_seq #(.OPERAND_WIDTH(16)) dut16 (
        .Clock(Clock), .Reset(Reset), .iStart(s16), .iA(a16), .iB(b16),
        .oBusy(busy16), .oDone(d16), .oResult(r16)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    always @(negedge Clock) begin
        if (d4)  dones4++;
        if (d8)  dones8++;
        if (d16) dones16++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int w, input logic s, input logic [15:0] a, input logic [15:0] b);
        case (w)
            4:       begin s4  = s; a4  = a[3:0]; b4  = b[3:0]; end
            8:       begin s8  = s; a8  = a[7:0]; b8  = b[7:0]; end
            default: begin s16 = s; a16 = a;      b16 = b;      end
        endcase
    endtask

    function automatic logic get_busy(input int w);
        case (w)
            4:       return busy4;
            8:       return busy8;
            default: return busy16;
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            4:       return d4;
            8:       return d8;
            default: return d16;
        endcase
    endfunction

    function automatic logic [31:0] get_res(input int w);
        case (w)
            4:       return 32'(r4);
            8:       return 32'(r8);
            default: return r16;
        endcase
    endfunction

    task automatic bump_exp(input int w);
        case (w)
            4:       exp4++;
            8:       exp8++;
            default: exp16++;
        endcase
    endtask

    // Called at a negedge with the DUT idle. Expected product and step count
    // come straight from arithmetic: a*b after (w/4)^2 steps.
    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                          input bit noisy, input string tag);
        int          steps = (w / 4) * (w / 4);
        logic [31:0] e     = 32'(a) * 32'(b);
        int          k     = 0;
        int          busy_n = 0;
        set_in(w, 1'b1, a, b);
        @(negedge Clock);
        set_in(w, 1'b0, 16'h0, 16'h0);
        while (!get_done(w) && k < 64) begin
            if (get_busy(w)) busy_n++;
            if (noisy) set_in(w, 1'($urandom), 16'($urandom), 16'($urandom));
            @(negedge Clock);
            k++;
        end
        set_in(w, 1'b0, 16'h0, 16'h0);
        check({tag, "_lat"},  64'(k), 64'(steps));
        check({tag, "_busy"}, 64'(busy_n), 64'(steps));
        check({tag, "_res"},  64'(get_res(w)), 64'(e));
        check({tag, "_idle"}, 64'(get_busy(w)), 64'd0);
        bump_exp(w);
        @(negedge Clock);
        check({tag, "_pulse"}, 64'(get_done(w)), 64'd0);
        check({tag, "_hold"},  64'(get_res(w)), 64'(e));
    endtask

    initial begin
        int last;
        int nd;
        int cnt0;
        Reset = 1'b0;
        set_in(4, 1'b0, 16'h0, 16'h0);
        set_in(8, 1'b0, 16'h0, 16'h0);
        set_in(16, 1'b0, 16'h0, 16'h0);
        repeat (2) @(negedge Clock);
        check("rst_busy", 64'({busy4, busy8, busy16}), 64'd0);
        check("rst_done", 64'({d4, d8, d16}), 64'd0);
        check("rst_res4", 64'(r4), 64'd0);
        check("rst_res8", 64'(r8), 64'd0);
        check("rst_res16", 64'(r16), 64'd0);
        Reset = 1'b1;
        @(negedge Clock);

        run_op(8, 16'hFF, 16'hFF, 1'b0, "ff_ff");
        check("ff_ff_val", 64'(r8), 64'hFE01);
        run_op(8, 16'd12, 16'd13, 1'b0, "12_13");
        check("12_13_val", 64'(r8), 64'h009C);
        run_op(8, 16'h00, 16'hA5, 1'b0, "00_a5");

        // iStart held high: a new op every 5 cycles; iA scrambled while busy.
        set_in(8, 1'b1, 16'h10, 16'h10);
        last = -1;
        nd   = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge Clock);
            if (d8) begin
                check("held_res", 64'(r8), 64'h0100);
                if (last < 0) check("held_first", 64'(n), 64'd5);
                else          check("held_gap", 64'(n - last), 64'd5);
                last = n;
                nd++;
                set_in(8, 1'b1, 16'h10, 16'h10);
            end else begin
                set_in(8, 1'b1, 16'($urandom), 16'h10);
            end
        end
        set_in(8, 1'b0, 16'h0, 16'h0);
        check("held_cnt", 64'(nd), 64'd4);
        exp8 += 4;

        // Reset during step 2 aborts without a done pulse.
        set_in(8, 1'b1, 16'h80, 16'h02);
        @(negedge Clock);
        set_in(8, 1'b0, 16'h0, 16'h0);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("abort_busy", 64'(busy8), 64'd0);
        check("abort_res", 64'(r8), 64'd0);
        check("abort_done", 64'(d8), 64'd0);
        @(negedge Clock);
        Reset = 1'b1;
        cnt0 = dones8;
        repeat (8) @(negedge Clock);
        check("abort_nodone", 64'(dones8 - cnt0), 64'd0);
        run_op(8, 16'h80, 16'h02, 1'b0, "restart");
        check("restart_val", 64'(r8), 64'h0100);

        run_op(4, 16'hF, 16'hF, 1'b0, "w4_ff");
        check("w4_ff_val", 64'(r4), 64'hE1);
        run_op(16, 16'hFFFF, 16'hFFFF, 1'b0, "w16_ffff");
        check("w16_ffff_val", 64'(r16), 64'hFFFE0001);

        for (int n = 0; n < 1000; n++)
            run_op(8, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'b1, "rnd8");
        for (int n = 0; n < 1000; n++)
            run_op(16, 16'($urandom), 16'($urandom), 1'b1, "rnd16");

        check("dones4", 64'(dones4), 64'(exp4));
        check("dones8", 64'(dones8), 64'(exp8));
        check("dones16", 64'(dones16), 64'(exp16));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
